// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port SRAM controller between the instruction-fetch
//   requester (read only) and the MEM-stage data requester. The winner's
//   command is latched and held on the ctrl_* outputs for ACCESS_CYCLES
//   cycles. Read data is captured into a per-port register, and a
//   one-cycle ack is returned to the owner.
//
//   Optional build macro SRAM_ARB_RR_EN: round-robin arbitration on
//   simultaneous requests. When it is undefined, mem has priority over if.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch request + word address (held until if_ack)
//   if_rdata/if_ack   fetch read data / one-cycle completion pulse
//   if_stall          if_req & ~if_ack
//   mem_req/we/addr/wdata/be  data request (held until mem_ack)
//   mem_rdata/mem_ack data read result / one-cycle completion pulse
//   mem_stall         mem_req & ~mem_ack
//   ctrl_*            command to / read data from the SRAM controller
//   grant_mem         data port currently owns the SRAM
module sram_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic              ctrl_read_op,
  output logic              ctrl_write_op,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic [3:0]        ctrl_byte_mask,
  input  logic [DATA_W-1:0] ctrl_rdata,
  output logic              grant_mem
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                owner_mem_q, owner_mem_d;
  logic                ctrl_read_op_q, ctrl_read_op_d;
  logic                ctrl_write_op_q, ctrl_write_op_d;
  logic [ADDR_W-1:0]   ctrl_addr_q, ctrl_addr_d;
  logic [DATA_W-1:0]   ctrl_wdata_q, ctrl_wdata_d;
  logic [3:0]          ctrl_byte_mask_q, ctrl_byte_mask_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                pick_mem;

`ifdef SRAM_ARB_RR_EN
  logic                last_mem_q, last_mem_d;

  // A sole requester always wins; on a tie the port not granted last wins.
  assign pick_mem = mem_req & (~if_req | ~last_mem_q);
`else
  assign pick_mem = mem_req;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    owner_mem_d      = owner_mem_q;
    ctrl_read_op_d   = ctrl_read_op_q;
    ctrl_write_op_d  = ctrl_write_op_q;
    ctrl_addr_d      = ctrl_addr_q;
    ctrl_wdata_d     = ctrl_wdata_q;
    ctrl_byte_mask_d = ctrl_byte_mask_q;
    if_rdata_d       = if_rdata_q;
    mem_rdata_d      = mem_rdata_q;
    if_ack_d         = 1'b0;
    mem_ack_d        = 1'b0;
`ifdef SRAM_ARB_RR_EN
    last_mem_d       = last_mem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (if_req | mem_req) begin
          state_d     = ST_BUSY;
          cnt_d       = CNT_LOAD;
          owner_mem_d = pick_mem;
`ifdef SRAM_ARB_RR_EN
          last_mem_d  = pick_mem;
`endif
          // The command registers double as the ctrl_* outputs, so they
          // are loaded here and cleared again when BUSY ends.
          if (pick_mem) begin
            ctrl_read_op_d   = ~mem_we;
            ctrl_write_op_d  = mem_we;
            ctrl_addr_d      = mem_addr;
            ctrl_wdata_d     = mem_wdata;
            ctrl_byte_mask_d = mem_be;
          end else begin
            ctrl_read_op_d   = 1'b1;
            ctrl_write_op_d  = 1'b0;
            ctrl_addr_d      = if_addr;
            ctrl_wdata_d     = '0;
            ctrl_byte_mask_d = '1;
          end
        end
      end

      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d          = ST_DONE;
          ctrl_read_op_d   = 1'b0;
          ctrl_write_op_d  = 1'b0;
          ctrl_addr_d      = '0;
          ctrl_wdata_d     = '0;
          ctrl_byte_mask_d = '0;
          if (ctrl_read_op_q) begin
            if (owner_mem_q) mem_rdata_d = ctrl_rdata;
            else             if_rdata_d  = ctrl_rdata;
          end
          // Ack is registered so that it is high during the DONE cycle.
          if (owner_mem_q) mem_ack_d = 1'b1;
          else             if_ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      owner_mem_q      <= 1'b0;
      ctrl_read_op_q   <= 1'b0;
      ctrl_write_op_q  <= 1'b0;
      ctrl_addr_q      <= '0;
      ctrl_wdata_q     <= '0;
      ctrl_byte_mask_q <= '0;
      if_rdata_q       <= '0;
      mem_rdata_q      <= '0;
      if_ack_q         <= 1'b0;
      mem_ack_q        <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_mem_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      owner_mem_q      <= owner_mem_d;
      ctrl_read_op_q   <= ctrl_read_op_d;
      ctrl_write_op_q  <= ctrl_write_op_d;
      ctrl_addr_q      <= ctrl_addr_d;
      ctrl_wdata_q     <= ctrl_wdata_d;
      ctrl_byte_mask_q <= ctrl_byte_mask_d;
      if_rdata_q       <= if_rdata_d;
      mem_rdata_q      <= mem_rdata_d;
      if_ack_q         <= if_ack_d;
      mem_ack_q        <= mem_ack_d;
`ifdef SRAM_ARB_RR_EN
      last_mem_q       <= last_mem_d;
`endif
    end
  end

  assign ctrl_read_op   = ctrl_read_op_q;
  assign ctrl_write_op  = ctrl_write_op_q;
  assign ctrl_addr      = ctrl_addr_q;
  assign ctrl_wdata     = ctrl_wdata_q;
  assign ctrl_byte_mask = ctrl_byte_mask_q;
  assign if_rdata       = if_rdata_q;
  assign mem_rdata      = mem_rdata_q;
  assign if_ack         = if_ack_q;
  assign mem_ack        = mem_ack_q;
  assign if_stall       = if_req & ~if_ack_q;
  assign mem_stall      = mem_req & ~mem_ack_q;
  assign grant_mem      = (state_q != ST_IDLE) & owner_mem_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned AC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] if_rdata, mem_rdata, ctrl_wdata, ctrl_rdata;
  logic          if_ack, if_stall, mem_ack, mem_stall;
  logic          ctrl_read_op, ctrl_write_op, grant_mem;
  logic [AW-1:0] ctrl_addr;
  logic [3:0]    ctrl_byte_mask;

  // Second instance with a one-cycle access time.
  logic          mem_req1, mem_we1;
  logic [AW-1:0] mem_addr1, ctrl_addr1;
  logic [DW-1:0] if_rdata1, mem_rdata1, ctrl_wdata1, ctrl_rdata1;
  logic          if_ack1, if_stall1, mem_ack1, mem_stall1;
  logic          ctrl_read_op1, ctrl_write_op1, grant_mem1;
  logic [3:0]    ctrl_byte_mask1;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .ctrl_read_op(ctrl_read_op), .ctrl_write_op(ctrl_write_op), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_byte_mask(ctrl_byte_mask), .ctrl_rdata(ctrl_rdata),
    .grant_mem(grant_mem)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr('0), .if_rdata(if_rdata1), .if_ack(if_ack1), .if_stall(if_stall1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata('0), .mem_be(4'hF),
    .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .mem_stall(mem_stall1),
    .ctrl_read_op(ctrl_read_op1), .ctrl_write_op(ctrl_write_op1), .ctrl_addr(ctrl_addr1),
    .ctrl_wdata(ctrl_wdata1), .ctrl_byte_mask(ctrl_byte_mask1), .ctrl_rdata(ctrl_rdata1),
    .grant_mem(grant_mem1)
  );

  // Environment SRAM: 64 words, applies byte-masked writes issued by the DUT.
  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] v;
    v = 32'h9E37_79B9 * 32'(i + 1);
    return (i == 16) ? 32'h3C08_8000 : v;
  endfunction

  logic          load_mem;
  logic [DW-1:0] sram [0:63];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else if (ctrl_write_op) begin
      for (int b = 0; b < 4; b++)
        if (ctrl_byte_mask[b]) sram[ctrl_addr[5:0]][8*b +: 8] <= ctrl_wdata[8*b +: 8];
    end
  end
  assign ctrl_rdata  = sram[ctrl_addr[5:0]];
  assign ctrl_rdata1 = {12'hC0D, ctrl_addr1};

  // Reference model state
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] exp_if_rdata, exp_mem_rdata;
  bit            last_mem;

  task automatic model_reset();
    last_mem      = 1'b0;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
  endtask

  // Drive one or two simultaneous requests from IDLE and check every cycle
  // until all of them are acked. Transaction slot 0 is busy in cycles 1..AC
  // and acks at AC+1; slot 1 is busy in AC+3..2AC+2 and acks at 2AC+3.
  task automatic run_round(input bit do_if, input bit do_mem, input logic [AW-1:0] ia,
                           input bit mwe, input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                           input logic [3:0] mbe, output bit obs_first_mem);
    bit            first_mem, own, busy, is_ack, two;
    logic          e_rd, e_wr, e_iack, e_mack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, w;
    logic [3:0]    e_be;
    int            kmax;
    @(negedge clk);
    if_req = do_if; if_addr = ia;
    mem_req = do_mem; mem_we = mwe; mem_addr = ma; mem_wdata = mwd; mem_be = mbe;
`ifdef SRAM_ARB_RR_EN
    first_mem = do_mem && (!do_if || !last_mem);
`else
    first_mem = do_mem;
`endif
    two = do_if && do_mem;
    last_mem = two ? !first_mem : first_mem;
    kmax = two ? int'(2*AC + 3) : int'(AC + 1);
    obs_first_mem = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1) obs_first_mem = grant_mem;
      own    = (k <= int'(AC + 1)) ? first_mem : !first_mem;
      busy   = (k <= int'(AC)) || (two && k >= int'(AC + 3) && k <= int'(2*AC + 2));
      is_ack = (k == int'(AC + 1)) || (two && k == int'(2*AC + 3));
      e_rd   = busy && (own ? !mwe : 1'b1);
      e_wr   = busy && own && mwe;
      e_addr = !busy ? '0 : (own ? ma : ia);
      e_wd   = (busy && own) ? mwd : '0;
      e_be   = !busy ? 4'h0 : (own ? mbe : 4'hF);
      e_iack = is_ack && !own;
      e_mack = is_ack && own;
      if (e_mack) begin
        if (mwe) begin
          w = ref_mem[ma[5:0]];
          for (int b = 0; b < 4; b++) if (mbe[b]) w[8*b +: 8] = mwd[8*b +: 8];
          ref_mem[ma[5:0]] = w;
        end else exp_mem_rdata = ref_mem[ma[5:0]];
      end
      if (e_iack) exp_if_rdata = ref_mem[ia[5:0]];
      checks++; if (ctrl_read_op !== e_rd) begin failures++; $display("FAIL ctrl_read_op k=%0d got=%b exp=%b", k, ctrl_read_op, e_rd); end
      checks++; if (ctrl_write_op !== e_wr) begin failures++; $display("FAIL ctrl_write_op k=%0d got=%b exp=%b", k, ctrl_write_op, e_wr); end
      checks++; if (ctrl_addr !== e_addr) begin failures++; $display("FAIL ctrl_addr k=%0d got=%h exp=%h", k, ctrl_addr, e_addr); end
      checks++; if (ctrl_wdata !== e_wd) begin failures++; $display("FAIL ctrl_wdata k=%0d got=%h exp=%h", k, ctrl_wdata, e_wd); end
      checks++; if (ctrl_byte_mask !== e_be) begin failures++; $display("FAIL ctrl_byte_mask k=%0d got=%h exp=%h", k, ctrl_byte_mask, e_be); end
      checks++; if (if_ack !== e_iack) begin failures++; $display("FAIL if_ack k=%0d got=%b exp=%b", k, if_ack, e_iack); end
      checks++; if (mem_ack !== e_mack) begin failures++; $display("FAIL mem_ack k=%0d got=%b exp=%b", k, mem_ack, e_mack); end
      checks++; if (if_rdata !== exp_if_rdata) begin failures++; $display("FAIL if_rdata k=%0d got=%h exp=%h", k, if_rdata, exp_if_rdata); end
      checks++; if (mem_rdata !== exp_mem_rdata) begin failures++; $display("FAIL mem_rdata k=%0d got=%h exp=%h", k, mem_rdata, exp_mem_rdata); end
      checks++; if (if_stall !== (if_req & !e_iack)) begin failures++; $display("FAIL if_stall k=%0d got=%b exp=%b", k, if_stall, if_req & !e_iack); end
      checks++; if (mem_stall !== (mem_req & !e_mack)) begin failures++; $display("FAIL mem_stall k=%0d got=%b exp=%b", k, mem_stall, mem_req & !e_mack); end
      checks++; if (grant_mem !== ((busy || is_ack) && own)) begin failures++; $display("FAIL grant_mem k=%0d got=%b exp=%b", k, grant_mem, (busy || is_ack) && own); end
      if (e_iack) if_req = 1'b0;
      if (e_mack) mem_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req = 1'($urandom); mem_req = 1'($urandom); mem_we = 1'($urandom);
      if_addr = AW'($urandom); mem_addr = AW'($urandom);
    end
    @(negedge clk);
    checks++; if ({ctrl_read_op, ctrl_write_op, if_ack, mem_ack, grant_mem} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {ctrl_read_op, ctrl_write_op, if_ack, mem_ack, grant_mem}); end
    checks++; if ({ctrl_addr, ctrl_wdata, ctrl_byte_mask} !== '0) begin failures++; $display("FAIL reset_ctrl got=%h/%h/%h exp=0", ctrl_addr, ctrl_wdata, ctrl_byte_mask); end
    checks++; if ({if_rdata, mem_rdata} !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, mem_rdata); end
    checks++; if ({if_stall, mem_stall} !== {if_req, mem_req}) begin failures++; $display("FAIL reset_stall got=%b exp=%b", {if_stall, mem_stall}, {if_req, mem_req}); end
    if_req = 1'b0; mem_req = 1'b0; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch_read();
    bit f;
    run_round(1'b1, 1'b0, 20'h00010, 1'b0, '0, '0, 4'h0, f);
    checks++; if (if_rdata !== 32'h3C08_8000) begin failures++; $display("FAIL fetch_rdata got=%h exp=3c088000", if_rdata); end
  endtask

  task automatic test_data_write();
    bit f;
    logic [DW-1:0] prev, base, exp_w;
    prev = exp_mem_rdata;
    run_round(1'b0, 1'b1, '0, 1'b1, 20'h80004, 32'hDEAD_BEEF, 4'b0011, f);
    checks++; if (mem_rdata !== prev) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=%h", mem_rdata, prev); end
    run_round(1'b0, 1'b1, '0, 1'b0, 20'h80004, '0, 4'h0, f);
    base  = init_word(4);
    exp_w = {base[31:16], 16'hBEEF};
    checks++; if (mem_rdata !== exp_w) begin failures++; $display("FAIL write_readback got=%h exp=%h", mem_rdata, exp_w); end
  endtask

  task automatic test_conflict();
    bit f, exp_f;
`ifdef SRAM_ARB_RR_EN
    exp_f = !last_mem;
`else
    exp_f = 1'b1;
`endif
    run_round(1'b1, 1'b1, 20'h00021, 1'b0, 20'h00022, '0, 4'hF, f);
    checks++; if (f !== exp_f) begin failures++; $display("FAIL conflict_first_grant got=%b exp=%b", f, exp_f); end
  endtask

`ifdef SRAM_ARB_RR_EN
  task automatic test_round_robin();
    bit f;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < 2; r++) begin
      run_round(1'b1, 1'b1, AW'(r + 40), 1'b0, AW'(r + 50), '0, 4'hF, f);
      checks++; if (f !== 1'b1) begin failures++; $display("FAIL rr_first_grant r=%0d got=%b exp=1", r, f); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit f;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h00007; mem_wdata = 32'h1234_5678; mem_be = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ctrl_write_op !== 1'b1) begin failures++; $display("FAIL mid_busy_write got=%b exp=1", ctrl_write_op); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0;
    model_reset();
    checks++; if ({ctrl_write_op, mem_ack, grant_mem} !== 3'b000) begin failures++; $display("FAIL mid_abort got=%b exp=000", {ctrl_write_op, mem_ack, grant_mem}); end
    checks++; if (mem_rdata !== '0) begin failures++; $display("FAIL mid_rdata_clear got=%h exp=0", mem_rdata); end
    @(negedge clk);
    checks++; if ({mem_ack, ctrl_write_op} !== 2'b00) begin failures++; $display("FAIL mid_no_ack got=%b exp=00", {mem_ack, ctrl_write_op}); end
    run_round(1'b1, 1'b0, 20'h00010, 1'b0, '0, '0, 4'h0, f);
    checks++; if (if_rdata !== 32'h3C08_8000) begin failures++; $display("FAIL mid_after_read got=%h exp=3c088000", if_rdata); end
  endtask

  task automatic test_random();
    bit f;
    logic [1:0] r;
    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      run_round(r[0], r[1], AW'($urandom_range(0, 63)), 1'($urandom), AW'($urandom_range(0, 63)),
                32'($urandom), 4'($urandom_range(0, 15)), f);
    end
  endtask

  task automatic test_access_one();
    logic          e_rd, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
    @(negedge clk);
    mem_req1 = 1'b1; mem_we1 = 1'b0; mem_addr1 = 20'h00000;
    e_rdata = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e_rd   = (k == 1) || (k == 4);
      e_ack  = (k == 2) || (k == 5);
      e_addr = (k == 1) ? 20'h00000 : (k == 4) ? 20'h00001 : 20'h00000;
      if (k == 2) e_rdata = 32'hC0D0_0000;
      if (k == 5) e_rdata = 32'hC0D0_0001;
      checks++; if (ctrl_read_op1 !== e_rd) begin failures++; $display("FAIL ac1_read_op k=%0d got=%b exp=%b", k, ctrl_read_op1, e_rd); end
      checks++; if (ctrl_addr1 !== e_addr) begin failures++; $display("FAIL ac1_addr k=%0d got=%h exp=%h", k, ctrl_addr1, e_addr); end
      checks++; if (mem_ack1 !== e_ack) begin failures++; $display("FAIL ac1_ack k=%0d got=%b exp=%b", k, mem_ack1, e_ack); end
      checks++; if (mem_rdata1 !== e_rdata) begin failures++; $display("FAIL ac1_rdata k=%0d got=%h exp=%h", k, mem_rdata1, e_rdata); end
      if (k == 2) mem_addr1 = 20'h00001;
      if (k == 5) mem_req1 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; load_mem = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    mem_req1 = 1'b0; mem_we1 = 1'b0; mem_addr1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_conflict();
`ifdef SRAM_ARB_RR_EN
    test_round_robin();
`endif
    test_reset_mid();
    test_random();
    test_access_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM port (the single-port SRAM controller) between the instruction-fetch requester and the MEM-stage data requester.
- Arbitrates between them and holds the winner's command stable on the controller side for a fixed number of access cycles.
- Captures read data, returns a one-cycle ack, and drives per-requester stall signals into the pipeline.

Parameters:
- ADDR_W, 20, SRAM word-address width (Ram_addr_t).
- DATA_W, 32, data width (Word_t).
- ACCESS_CYCLES, 3, cycles a command is held on the controller side; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (read only); held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  DATA_W  fetch read data, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for the fetch port
- if_stall  out  1  if_req & ~if_ack
- mem_req  in  1  data request; held with all mem_* inputs until mem_ack
- mem_we  in  1  1=write, 0=read
- mem_addr  in  ADDR_W  data word address
- mem_wdata  in  DATA_W  write data
- mem_be  in  4  byte mask, active high
- mem_rdata  out  DATA_W  data read result, valid when mem_ack=1
- mem_ack  out  1  one-cycle completion pulse for the data port
- mem_stall  out  1  mem_req & ~mem_ack
- ctrl_read_op  out  1  read command to the SRAM controller
- ctrl_write_op  out  1  write command to the SRAM controller
- ctrl_addr  out  ADDR_W  controller address
- ctrl_wdata  out  DATA_W  controller write data
- ctrl_byte_mask  out  4  controller byte mask
- ctrl_rdata  in  DATA_W  controller read data
- grant_mem  out  1  1 while the data port owns the SRAM (debug/visibility)

Behaviour:
- Reset and outputs:
  - Synchronous reset to IDLE. All outputs are 0, the cycle counter is 0, and both rdata registers are 0.
  - A reset during BUSY or DONE aborts the access immediately. No ack is produced, and ctrl_* drop on the next cycle.
- FSM states:
  - IDLE: if any req is high at the clock edge, latch the winner's command into registers, set the owner, load counter=ACCESS_CYCLES-1, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: drive ctrl_* from the latched registers. ctrl_read_op = ~we and ctrl_write_op = we; exactly one is high. Decrement the counter. At counter==0 and owner reads, capture ctrl_rdata into the owner's rdata register, then go to DONE.
  - DONE: ctrl_* all 0. The owner's ack is 1 for exactly this cycle. Requests are ignored in DONE. Next state is IDLE.
- Outside BUSY, ctrl_* are 0, including addr, wdata and mask.
- Latency: request accepted at edge t (state IDLE). ctrl command is valid for cycles t+1 .. t+ACCESS_CYCLES. Ack occurs in cycle t+ACCESS_CYCLES+1. The minimum gap between successive grants is ACCESS_CYCLES+2 cycles.
- Fetch commands are always reads: mask 4'b1111, wdata 0.
- The non-owner's req is ignored while another access is in flight. Its stall stays 1 and it is arbitrated at the next IDLE.
- Handshake:
  - A requester deasserts req (or presents a new command) the cycle after ack.
  - A req still high in IDLE after ack is a new access.
  - Input changes during BUSY have no effect, because the command is latched.
- Write with mem_be=0: the access runs full length and acks normally. No data is modified.
- rdata registers hold their value until the next read by the same port. Writes do not change mem_rdata.
- Priority with the macro off: mem over if on simultaneous requests.
- grant_mem = (state!=IDLE) & owner==mem.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner register is reset to if. On simultaneous requests the port not granted last wins; a sole requester always wins. last_owner updates on each grant.
- Undefined: fixed priority, mem over if. No last_owner register.

Test Plan:
- Fetch read:
  - Stimulus: rst, then if_req=1, if_addr=0x00010; ctrl_rdata returns 0x3C08_8000.
  - Required: ctrl_read_op high for exactly 3 cycles with ctrl_addr=0x00010; if_ack one cycle later; if_rdata=0x3C08_8000; if_stall drops with the ack.
- Data write:
  - Stimulus: mem_req=1, mem_we=1, addr 0x80004, wdata 0xDEADBEEF, be=4'b0011.
  - Required: ctrl_write_op high 3 cycles with matching addr, data and mask 0011; ctrl_read_op=0; mem_ack pulse; mem_rdata unchanged.
- Conflict, macro off:
  - Stimulus: if_req and mem_req rise in the same cycle.
  - Required: mem is served first (ack at +4); if is granted in the following IDLE (ack at +9); if_stall=1 throughout until its ack.
- Conflict, SRAM_ARB_RR_EN:
  - Stimulus: both requesters continuously re-request for 4 accesses.
  - Required: grants alternate mem, if, mem, if (last_owner reset=if, so mem first).
- Reset mid-access:
  - Stimulus: assert rst in the 2nd BUSY cycle of a mem write.
  - Required: ctrl_write_op=0 next cycle; no mem_ack; state IDLE; a new if read afterward completes normally.
- ACCESS_CYCLES=1:
  - Stimulus: back-to-back mem reads to 0x00000 and 0x00001.
  - Required: each command is held 1 cycle, acks 3 cycles apart, rdata matches each ctrl_rdata value.
